// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Packs decoded instruction fields into 32-bit ARM-format words and streams them, one per
//   cycle, into instruction memory starting at BASE_ADDR after each start pulse.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse; begins/restarts a load session
//   req_valid/req_ready  request handshake from the program loader
//   req_last             final request of the session
//   req_cond/op/funct/rn/rd/src2/imm24   decoded instruction fields
//   mem_we/addr/wdata    instruction-memory write port (registered, 1-cycle latency)
//   busy, done, full     session status (LOAD, DONE, count == DEPTH)
//   err                  sticky illegal-op flag for the current session
//   count                legal words written this session
module instr_stream_encoder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_last,
    input  logic [3:0]                     req_cond,
    input  logic [1:0]                     req_op,
    input  logic [5:0]                     req_funct,
    input  logic [3:0]                     req_rn,
    input  logic [3:0]                     req_rd,
    input  logic [11:0]                    req_src2,
    input  logic [23:0]                    req_imm24,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           busy,
    output logic                           done,
    output logic                           full,
    output logic                           err,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e              state;
    logic [ADDR_W-1:0]   ptr;
    logic [31:0]         word;
    logic                accept;
    logic                legal;

    assign busy  = (state == StLoad);
    assign done  = (state == StDone);
    assign full  = (count == CntW'(DEPTH));

    // start wins over a same-cycle request, so it must gate ready.
    assign req_ready = busy && !start && (count < CntW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign legal     = (req_op != 2'd3);

    always_comb begin
        word = '0;
        if (req_op == 2'd2) begin
            word = {req_cond, 2'b10, req_funct[5:4], req_imm24};
        end else begin
            word = {req_cond, req_op, req_funct, req_rn, req_rd, req_src2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            ptr       <= ADDR_W'(BASE_ADDR);
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state <= StLoad;
                ptr   <= ADDR_W'(BASE_ADDR);
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= word;
                    ptr       <= ptr + ADDR_W'(4);
                    count     <= count + CntW'(1);
                end else begin
                    // Illegal op: handshake completes but nothing is written.
                    err <= 1'b1;
                end
                if (req_last || (legal && (count == CntW'(DEPTH - 1)))) begin
                    state <= StDone;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BASE   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_last = 1'b0;
    logic [3:0]        req_cond = '0;
    logic [1:0]        req_op = '0;
    logic [5:0]        req_funct = '0;
    logic [3:0]        req_rn = '0;
    logic [3:0]        req_rd = '0;
    logic [11:0]       req_src2 = '0;
    logic [23:0]       req_imm24 = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, full, err;
    logic [$clog2(DEPTH+1)-1:0] count;

    always #5 clk = ~clk;

    instr_stream_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_last  (req_last),
        .req_cond  (req_cond),
        .req_op    (req_op),
        .req_funct (req_funct),
        .req_rn    (req_rn),
        .req_rd    (req_rd),
        .req_src2  (req_src2),
        .req_imm24 (req_imm24),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .err       (err),
        .count     (count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: session phase (0 idle, 1 loading, 2 finished) and expected outputs.
    int          m_phase = 0;
    int          m_count = 0;
    bit          m_err   = 0;
    int unsigned m_ptr   = BASE;
    bit          e_we    = 0;
    logic [31:0] e_addr  = '0;
    logic [31:0] e_data  = '0;

    function automatic logic [31:0] model_word();
        int unsigned w;
        if (req_op == 2'd2)
            w = (32'(req_cond) << 28) + (32'd2 << 26) + ((32'(req_funct) >> 4) << 24)
                + 32'(req_imm24);
        else
            w = (32'(req_cond) << 28) + (32'(req_op) << 26) + (32'(req_funct) << 20)
                + (32'(req_rn) << 16) + (32'(req_rd) << 12) + 32'(req_src2);
        return w;
    endfunction

    task automatic check_outs();
        check_eq("mem_we", 32'(mem_we), 32'(e_we));
        check_eq("mem_addr", 32'(mem_addr), e_addr);
        check_eq("mem_wdata", mem_wdata, e_data);
        check_eq("count", 32'(count), 32'(m_count));
        check_eq("full", 32'(full), 32'(m_count == DEPTH));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("busy", 32'(busy), 32'(m_phase == 1));
        check_eq("done", 32'(done), 32'(m_phase == 2));
    endtask

    task automatic drive(input bit st, input bit v, input bit last, input logic [3:0] c,
                         input logic [1:0] op, input logic [5:0] f, input logic [3:0] rn,
                         input logic [3:0] rd, input logic [11:0] s2, input logic [23:0] imm);
        start = st; req_valid = v; req_last = last; req_cond = c; req_op = op;
        req_funct = f; req_rn = rn; req_rd = rd; req_src2 = s2; req_imm24 = imm;
    endtask

    // Called shortly after a rising edge with inputs already driven; advances one cycle.
    task automatic tick();
        bit ready, acc;
        ready = (m_phase == 1) && !start && (m_count < DEPTH);
        #1;
        check_eq("req_ready", 32'(req_ready), 32'(ready));
        acc  = ready && req_valid;
        e_we = 0;
        if (start) begin
            m_phase = 1; m_count = 0; m_err = 0; m_ptr = BASE;
        end else if (acc) begin
            if (req_op != 2'd3) begin
                e_we = 1; e_addr = m_ptr; e_data = model_word();
                m_ptr = (m_ptr + 4) % (1 << ADDR_W);
                m_count++;
            end else begin
                m_err = 1;
            end
            if (req_last || m_count == DEPTH) m_phase = 2;
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic idle_tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        #12;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_outs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Data-processing and branch encodings from known words.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 4'hE, 2'd0, 6'b101000, 4'd1, 4'd2, 12'h005, 0); tick();
        check_eq("enc_dp", mem_wdata, 32'hE2812005);
        check_eq("addr_first", 32'(mem_addr), BASE);
        drive(0, 1, 1, 4'h0, 2'd2, 6'b100000, 0, 0, 0, 24'hFFFFFE); tick();
        check_eq("enc_br", mem_wdata, 32'h0AFFFFFE);
        idle_tick();

        // Three back-to-back, last on third.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i == 2, 4'(i + 1), 2'd1, 6'(i * 5), 4'(i), 4'(i + 7), 12'(i * 99), 0);
            tick();
        end
        check_eq("b2b_done", 32'(done), 32'd1);
        check_eq("b2b_addr3", 32'(mem_addr), BASE + 8);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Illegal op between two legal ones.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 4'h3, 2'd0, 6'h11, 4'd4, 4'd5, 12'hABC, 0); tick();
        drive(0, 1, 0, 4'h3, 2'd3, 6'h11, 4'd4, 4'd5, 12'hABC, 0); tick();
        check_eq("ill_err", 32'(err), 32'd1);
        drive(0, 1, 1, 4'h7, 2'd1, 6'h2A, 4'd9, 4'd1, 12'h123, 0); tick();
        check_eq("ill_count", 32'(count), 32'd2);

        // Overflow: valid held for six cycles, no last.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 4'hA, 2'd0, 6'(i), 4'(i), 4'(i), 12'(i), 0); tick();
        end
        check_eq("ovf_full", 32'(full), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        check_eq("restart_count", 32'(count), 32'd0);

        // Reset while a write is on the port.
        drive(0, 1, 0, 4'h5, 2'd0, 6'h01, 4'd2, 4'd3, 12'h0FF, 0); tick();
        #2 rst_n = 1'b0;
        #1;
        m_phase = 0; m_count = 0; m_err = 0; m_ptr = BASE;
        e_we = 0; e_addr = '0; e_data = '0;
        check_eq("rst_ready_mid", 32'(req_ready), 32'd0);
        check_outs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, 0, 4'h5, 2'd0, 6'h01, 4'd2, 4'd3, 12'h0FF, 0); tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 7) == 0, 4'($urandom), 2'($urandom), 6'($urandom),
                  4'($urandom), 4'($urandom), 12'($urandom), 24'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
